// File: rtl/fft_frame_source.sv
// Host-loaded N-sample complex frame, streamed downstream as START, N ED strobes (GAP idle
// cycles apart), then a wait for RDY_IN ending in a DONE pulse or a sticky ERR on timeout.
module fft_frame_source #(
   parameter int total_bits = 32,
   parameter int N          = 32,
   parameter int ADDR_W     = 5,
   parameter int GAP        = 0,
   parameter int TIMEOUT    = 255
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WE,
   input  logic [ADDR_W-1:0]     WADDR,
   input  logic [total_bits-1:0] WReal,
   input  logic [total_bits-1:0] WImag,
   input  logic                  GO,
   input  logic                  RDY_IN,
   output logic                  BUSY,
   output logic                  START,
   output logic                  ED,
   output logic [total_bits-1:0] DReal,
   output logic [total_bits-1:0] DImag,
   output logic                  DONE,
   output logic                  ERR
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_STRT, S_SEND, S_GAPW, S_WAIT} state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     idx_q, idx_d, idx_inc;
   logic [GW-1:0]         gap_q, gap_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  busy_q, busy_d;
   logic                  start_q, start_d;
   logic                  ed_q, ed_d;
   logic [total_bits-1:0] dreal_q, dreal_d;
   logic [total_bits-1:0] dimag_q, dimag_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [total_bits-1:0] mem_re_q [N];
   logic [total_bits-1:0] mem_im_q [N];

   // Storage only accepts writes while idle so a frame in flight can never change.
   always_ff @(posedge CLK) begin
      if (WE && state_q == S_IDLE) begin
         mem_re_q[WADDR] <= WReal;
         mem_im_q[WADDR] <= WImag;
      end
   end

   assign idx_inc = idx_q + ADDR_W'(1);

   // idx_q always names the sample currently presented on DReal/DImag while in SEND.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      tmo_d   = tmo_q;
      busy_d  = busy_q;
      start_d = 1'b0;
      ed_d    = 1'b0;
      dreal_d = dreal_q;
      dimag_d = dimag_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (GO) begin
               state_d = S_STRT;
               busy_d  = 1'b1;
               err_d   = 1'b0;
               start_d = 1'b1;
            end
         end
         S_STRT: begin
            state_d = S_SEND;
            idx_d   = '0;
            ed_d    = 1'b1;
            dreal_d = mem_re_q[0];
            dimag_d = mem_im_q[0];
         end
         S_SEND: begin
            if (idx_q == ADDR_W'(N - 1)) begin
               state_d = S_WAIT;
               tmo_d   = '0;
            end else begin
               idx_d = idx_inc;
               if (GAP > 0) begin
                  state_d = S_GAPW;
                  gap_d   = '0;
               end else begin
                  ed_d    = 1'b1;
                  dreal_d = mem_re_q[idx_inc];
                  dimag_d = mem_im_q[idx_inc];
               end
            end
         end
         S_GAPW: begin
            if (gap_q == GW'(GAP - 1)) begin
               state_d = S_SEND;
               ed_d    = 1'b1;
               dreal_d = mem_re_q[idx_q];
               dimag_d = mem_im_q[idx_q];
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         S_WAIT: begin
            if (RDY_IN) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         gap_q   <= '0;
         tmo_q   <= '0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         ed_q    <= 1'b0;
         dreal_q <= '0;
         dimag_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         tmo_q   <= tmo_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         ed_q    <= ed_d;
         dreal_q <= dreal_d;
         dimag_q <= dimag_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign BUSY  = busy_q;
   assign START = start_q;
   assign ED    = ed_q;
   assign DReal = dreal_q;
   assign DImag = dimag_q;
   assign DONE  = done_q;
   assign ERR   = err_q;

endmodule

// File: tb/tb_fft_frame_source.sv
// Directed bench: back-to-back instance (u0) and GAP=2 instance (u2) sharing the host write port.
module tb_fft_frame_source;

   logic        CLK = 1'b0;
   logic        RST, WE, GO0, GO2, RDY_IN;
   logic [4:0]  WADDR;
   logic [31:0] WReal, WImag;

   logic        BUSY0, START0, ED0, DONE0, ERR0;
   logic [31:0] DReal0, DImag0;
   logic        BUSY2, START2, ED2, DONE2, ERR2;
   logic [31:0] DReal2, DImag2;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt0   = 0;
   int start_cnt0  = 0;

   always #5 CLK = ~CLK;

   fft_frame_source #(.total_bits(32), .N(32), .ADDR_W(5), .GAP(0), .TIMEOUT(255)) u0 (
      .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WReal(WReal), .WImag(WImag),
      .GO(GO0), .RDY_IN(RDY_IN), .BUSY(BUSY0), .START(START0), .ED(ED0),
      .DReal(DReal0), .DImag(DImag0), .DONE(DONE0), .ERR(ERR0));

   fft_frame_source #(.total_bits(32), .N(32), .ADDR_W(5), .GAP(2), .TIMEOUT(255)) u2 (
      .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WReal(WReal), .WImag(WImag),
      .GO(GO2), .RDY_IN(RDY_IN), .BUSY(BUSY2), .START(START2), .ED(ED2),
      .DReal(DReal2), .DImag(DImag2), .DONE(DONE2), .ERR(ERR2));

   always @(negedge CLK) begin
      if (DONE0)  done_cnt0++;
      if (START0) start_cnt0++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done0(input string tag);
      int c = 0;
      while (!DONE0 && c < 80) begin
         tick();
         c++;
      end
      chk(tag, DONE0, 1'b1);
      chk({tag, "_busy"}, BUSY0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int s_base, d_base, span;
      RST = 1'b1; WE = 1'b0; GO0 = 1'b0; GO2 = 1'b0; RDY_IN = 1'b0;
      WADDR = '0; WReal = '0; WImag = '0;
      #1;
      chk("rst_start", START0, 1'b0);
      chk("rst_ed", ED0, 1'b0);
      chk("rst_dreal", DReal0, 32'd0);
      chk("rst_busy", BUSY0, 1'b0);
      chk("rst_done", DONE0, 1'b0);
      chk("rst_err", ERR0, 1'b0);
      tick(); tick();
      RST = 1'b0;
      tick();

      // load frame: Real=i, Imag=100+i
      for (int i = 0; i < 32; i++) begin
         WE = 1'b1; WADDR = 5'(i); WReal = i; WImag = 100 + i;
         tick();
      end
      WE = 1'b0;

      // 1: back-to-back stream, RDY_IN two cycles after the last ED
      GO0 = 1'b1; tick(); GO0 = 1'b0;
      chk("t1_start", START0, 1'b1);
      chk("t1_start_ed", ED0, 1'b0);
      chk("t1_busy", BUSY0, 1'b1);
      tick();
      for (int i = 0; i < 32; i++) begin
         chk("t1_ed", ED0, 1'b1);
         chk("t1_no_start", START0, 1'b0);
         chk("t1_dreal", DReal0, 64'(i));
         chk("t1_dimag", DImag0, 64'(100 + i));
         tick();
      end
      chk("t1_wait_ed", ED0, 1'b0);
      chk("t1_wait_hold", DReal0, 32'd31);
      chk("t1_wait_busy", BUSY0, 1'b1);
      tick();
      RDY_IN = 1'b1;
      chk("t1_no_early_done", DONE0, 1'b0);
      tick();
      RDY_IN = 1'b0;
      chk("t1_done", DONE0, 1'b1);
      chk("t1_done_busy", BUSY0, 1'b0);
      tick();
      chk("t1_done_pulse", DONE0, 1'b0);

      // 2: GAP=2 stream, RDY_IN already high on WAIT entry
      GO2 = 1'b1; tick(); GO2 = 1'b0;
      chk("t2_start", START2, 1'b1);
      tick();
      span = 0;
      for (int i = 0; i < 32; i++) begin
         chk("t2_ed", ED2, 1'b1);
         chk("t2_dreal", DReal2, 64'(i));
         if (i < 31) begin
            tick(); span++;
            chk("t2_gap_a", ED2, 1'b0);
            tick(); span++;
            chk("t2_gap_b", ED2, 1'b0);
            tick(); span++;
         end
      end
      chk("t2_span", 64'(span + 1), 64'd94);
      RDY_IN = 1'b1;
      tick();
      chk("t2_wait_no_done", DONE2, 1'b0);
      tick();
      RDY_IN = 1'b0;
      chk("t2_done", DONE2, 1'b1);
      chk("t2_busy", BUSY2, 1'b0);

      // 3: timeout with RDY_IN held low
      tick();
      d_base = done_cnt0;
      GO0 = 1'b1; tick(); GO0 = 1'b0;
      repeat (287) tick();
      chk("t3_pre_err", ERR0, 1'b0);
      chk("t3_pre_busy", BUSY0, 1'b1);
      tick();
      chk("t3_err", ERR0, 1'b1);
      chk("t3_busy", BUSY0, 1'b0);
      repeat (3) tick();
      chk("t3_err_sticky", ERR0, 1'b1);
      chk("t3_no_done", 64'(done_cnt0 - d_base), 64'd0);

      // 4: resend clears ERR; WE and GO during SEND are ignored
      s_base = start_cnt0;
      d_base = done_cnt0;
      GO0 = 1'b1; tick(); GO0 = 1'b0;
      chk("t4_err_clr", ERR0, 1'b0);
      chk("t4_start", START0, 1'b1);
      tick();
      chk("t4_s0", DReal0, 32'd0);
      tick();
      WE = 1'b1; WADDR = 5'd5; WReal = 32'hBAD; WImag = 32'hBAD; GO0 = 1'b1; RDY_IN = 1'b1;
      tick();
      WE = 1'b0; GO0 = 1'b0;
      chk("t4_s2_busy", BUSY0, 1'b1);
      tick(); tick(); tick();
      chk("t4_s5_ed", ED0, 1'b1);
      chk("t4_s5_real", DReal0, 32'd5);
      chk("t4_s5_imag", DImag0, 32'd105);
      wait_done0("t4_done");
      RDY_IN = 1'b0;
      repeat (4) tick();
      chk("t4_one_start", 64'(start_cnt0 - s_base), 64'd1);
      chk("t4_one_done", 64'(done_cnt0 - d_base), 64'd1);

      // 5: async reset at sample 10
      GO0 = 1'b1; tick(); GO0 = 1'b0;
      tick();
      repeat (10) tick();
      chk("t5_s10", DReal0, 32'd10);
      #2 RST = 1'b1;
      #1;
      chk("t5_ed", ED0, 1'b0);
      chk("t5_start", START0, 1'b0);
      chk("t5_dreal", DReal0, 32'd0);
      chk("t5_dimag", DImag0, 32'd0);
      chk("t5_busy", BUSY0, 1'b0);
      #1 RST = 1'b0;
      tick();
      GO0 = 1'b1; tick(); GO0 = 1'b0;
      chk("t5_restart", START0, 1'b1);
      tick();
      chk("t5_first_ed", ED0, 1'b1);
      chk("t5_first_real", DReal0, 32'd0);
      RDY_IN = 1'b1;
      wait_done0("t5_done");
      RDY_IN = 1'b0;
      tick();

      // 6: same-cycle write to address 0 and GO
      WE = 1'b1; WADDR = 5'd0; WReal = 32'hDEAD; WImag = 32'd100; GO0 = 1'b1;
      tick();
      WE = 1'b0; GO0 = 1'b0;
      chk("t6_start", START0, 1'b1);
      tick();
      chk("t6_real", DReal0, 32'hDEAD);
      chk("t6_imag", DImag0, 32'd100);
      tick();
      chk("t6_s1", DReal0, 32'd1);
      RDY_IN = 1'b1;
      wait_done0("t6_done");
      RDY_IN = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
